encoding_vote_detector: RTL and testbench
=========================================

# encoding_vote_detector

Parametrised successor to the fixed six-input encoding auto-detector. Accepts NUM_SRC sync-pulse sources, each tagged with a run-time programmable encoding code and mask bit. It arbitrates simultaneous syncs by index priority and runs a lock/unlock state machine with configurable thresholds and a loss-of-sync timeout. It sits between the per-encoding sync detectors in the encoding mux and the encoding auto-select logic.

## Interface
Parameters:
- NUM_SRC, 8, number of sync sources (index 0 = highest priority)
- ENC_W, 3, encoding code width (ENC_* values)
- LOCK_THRESHOLD, 3, consecutive matches that cause lock (≥1)
- UNLOCK_THRESHOLD, 10, consecutive mismatches while locked that cause a switch (≥1)
- CNT_W, 8, match_count width
- TO_W, 20, timeout counter width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- enable  in  1  detector enable
- clear  in  1  synchronous soft reset, identical effect to reset
- sync_in  in  NUM_SRC  sync pulses/levels from decoders
- src_enc  in  NUM_SRC*ENC_W  encoding code of source i at bits [i*ENC_W +: ENC_W]
- src_mask  in  NUM_SRC  1 = source ignored (no edge, no history)
- timeout_cycles  in  TO_W  lock-loss timeout; 0 = disabled
- detected_encoding  out  ENC_W  current candidate encoding
- encoding_valid  out  1  at least one sync accepted since reset/enable
- encoding_locked  out  1  state == LOCKED
- lock_pulse  out  1  one-cycle pulse on entering LOCKED
- change_pulse  out  1  one-cycle pulse when detected_encoding changes value
- timeout_pulse  out  1  one-cycle pulse on timeout unlock
- match_count  out  CNT_W  saturating matches of current candidate
- sync_history  out  NUM_SRC  sticky per-source "edge ever seen"

## Operation
- Edge: edge[i] = sync_in[i] & ~prev[i] & ~src_mask[i]. prev updates every cycle, regardless of enable. prev resets to all-ones, so a level already high at reset is not an edge.
- Winner: lowest-index asserted edge. win_enc = its src_enc. Other simultaneous edges only set sync_history.
- States: SEARCH, TRACK, LOCKED.
- SEARCH, any edge: cand=win_enc, consec=1, match_count=1, valid=1. Go to TRACK, or to LOCKED if LOCK_THRESHOLD==1. change_pulse fires if win_enc differs from the held value.
- TRACK, win_enc==cand: consec+1, match_count+1 (saturating). If consec+1==LOCK_THRESHOLD, go to LOCKED with lock_pulse.
- TRACK, win_enc≠cand: cand=win_enc, consec=1, match_count=1, change_pulse.
- LOCKED, match: mismatch=0, match_count+1, to_cnt=0.
- LOCKED, mismatch: mismatch+1. When mismatch+1==UNLOCK_THRESHOLD, set cand=win_enc, consec=1, match_count=1, mismatch=0, go to TRACK, change_pulse.
- LOCKED timeout: timeout_cycles≠0 and timeout_cycles consecutive cycles pass without a matching edge. Go to TRACK with consec=0 and mismatch=0; cand is held; timeout_pulse fires. A mismatching edge does not reset to_cnt.
- enable low: state=SEARCH, valid=0, locked=0, consec/mismatch/to_cnt=0. detected_encoding, match_count and sync_history hold. No pulses.
- Counter widths: consec and mismatch saturate at their threshold widths (clog2(threshold)+1). to_cnt saturates at all-ones.

## Timing
- All outputs are registered. An edge sampled in cycle N is reflected in outputs at N+1. Pulses are high for exactly cycle N+1.
- Reset/clear values: detected_encoding=ENC_MFM(0), valid=0, locked=0, all pulses 0, match_count=0, sync_history=0, state=SEARCH.
- reset/clear asserted mid-lock takes effect at the next edge of clk. It has priority over enable and over edges in the same cycle.
- Timeout with a matching edge in the same cycle: the edge wins and no timeout occurs.
- lock_pulse and change_pulse are never asserted in the same cycle, except when LOCK_THRESHOLD==1.

## Structure
- encoding_pkg: ENC_MFM..ENC_TANDY constants, ENC_W, state enum.
- Sub-module sync_edge_priority: prev registers, masking, edge detection, lowest-index arbitration. Outputs any_edge, win_enc, edge vector.
- The top module holds the FSM, counters and timeout.

## Test plan
- Source 0 = ENC_GCR_AP6, three edges 10 cycles apart: valid at the first edge+1; locked and lock_pulse at the third edge+1; match_count=3.
- While locked, 9 mismatching edges (ENC_MFM): still locked, detected=AP6. The 10th edge gives TRACK, detected=MFM, change_pulse, match_count=1.
- Edges on sources 2 and 5 in the same cycle: detected = src_enc[2]; sync_history=8'b0010_0100.
- Locked with timeout_cycles=100 and no edges: timeout_pulse exactly 100 cycles after the last match; locked=0; encoding held.
- sync_in[1] high through reset release, then held high: no edge and valid stays 0. Masked source toggling: no effect.
- Drop enable while locked: locked=0, valid=0, detected held. reset mid-TRACK: all outputs return to reset values next cycle.

Source files
------------

// File: rtl/encoding_pkg.sv
// Shared encoding codes and detector state encoding for the encoding mux.
package encoding_pkg;

    localparam int ENC_CODE_W = 3;

    localparam logic [ENC_CODE_W-1:0] ENC_MFM     = 3'd0;
    localparam logic [ENC_CODE_W-1:0] ENC_FM      = 3'd1;
    localparam logic [ENC_CODE_W-1:0] ENC_GCR_C64 = 3'd2;
    localparam logic [ENC_CODE_W-1:0] ENC_GCR_AP6 = 3'd3;
    localparam logic [ENC_CODE_W-1:0] ENC_GCR_AP5 = 3'd4;
    localparam logic [ENC_CODE_W-1:0] ENC_TANDY   = 3'd5;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2
    } det_state_t;

endpackage

// File: rtl/encoding_vote_detector_sync_edge_priority.sv
// Rising-edge detection on masked sync sources with lowest-index arbitration.
module sync_edge_priority
    import encoding_pkg::*;
#(
    parameter int NUM_SRC = 8,
    parameter int ENC_W   = ENC_CODE_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic [NUM_SRC-1:0]         sync_in,
    input  logic [NUM_SRC*ENC_W-1:0]   src_enc,
    input  logic [NUM_SRC-1:0]         src_mask,
    output logic [NUM_SRC-1:0]         edge_vec,
    output logic                       any_edge,
    output logic [ENC_W-1:0]           win_enc
);

    logic [NUM_SRC-1:0] prev_q;

    // Previous-level register; all-ones after reset so a level already high is not an edge.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            prev_q <= '1;
        end else begin
            prev_q <= sync_in;
        end
    end

    assign edge_vec = sync_in & ~prev_q & ~src_mask;

    // Lowest asserted index wins; scanning downward lets lower indices overwrite.
    always_comb begin
        any_edge = |edge_vec;
        win_enc  = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (edge_vec[i]) begin
                win_enc = src_enc[i*ENC_W +: ENC_W];
            end
        end
    end

endmodule

// File: rtl/encoding_vote_detector.sv
// Lock/unlock voting FSM over arbitrated sync edges with loss-of-sync timeout.
// All outputs are registered status levels or one-cycle pulses; there is no
// handshake or backpressure, consumers simply sample them every cycle.
module encoding_vote_detector
    import encoding_pkg::*;
#(
    parameter int NUM_SRC          = 8,
    parameter int ENC_W            = ENC_CODE_W,
    parameter int LOCK_THRESHOLD   = 3,
    parameter int UNLOCK_THRESHOLD = 10,
    parameter int CNT_W            = 8,
    parameter int TO_W             = 20
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     clear,
    input  logic [NUM_SRC-1:0]       sync_in,
    input  logic [NUM_SRC*ENC_W-1:0] src_enc,
    input  logic [NUM_SRC-1:0]       src_mask,
    input  logic [TO_W-1:0]          timeout_cycles,
    output logic [ENC_W-1:0]         detected_encoding,
    output logic                     encoding_valid,
    output logic                     encoding_locked,
    output logic                     lock_pulse,
    output logic                     change_pulse,
    output logic                     timeout_pulse,
    output logic [CNT_W-1:0]         match_count,
    output logic [NUM_SRC-1:0]       sync_history
);

    localparam int LOCK_CW   = $clog2(LOCK_THRESHOLD) + 1;
    localparam int UNLOCK_CW = $clog2(UNLOCK_THRESHOLD) + 1;

    logic [NUM_SRC-1:0] edge_vec;
    logic               any_edge;
    logic [ENC_W-1:0]   win_enc;

    sync_edge_priority #(
        .NUM_SRC (NUM_SRC),
        .ENC_W   (ENC_W)
    ) u_edge (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .sync_in  (sync_in),
        .src_enc  (src_enc),
        .src_mask (src_mask),
        .edge_vec (edge_vec),
        .any_edge (any_edge),
        .win_enc  (win_enc)
    );

    det_state_t           state_q, state_d;
    logic [ENC_W-1:0]     cand_q, cand_d;
    logic [LOCK_CW-1:0]   consec_q, consec_d;
    logic [UNLOCK_CW-1:0] mism_q, mism_d;
    logic [TO_W-1:0]      to_q, to_d;
    logic [CNT_W-1:0]     mc_q, mc_d;
    logic                 valid_q, valid_d;
    logic [NUM_SRC-1:0]   hist_q, hist_d;
    logic                 lp_q, lp_d, cp_q, cp_d, tp_q, tp_d;

    logic                 match;
    logic                 timeout_hit;
    logic [TO_W:0]        to_inc;

    assign match       = any_edge && (win_enc == cand_q);
    assign to_inc      = {1'b0, to_q} + 1'b1;
    assign timeout_hit = (timeout_cycles != '0) && (to_inc >= {1'b0, timeout_cycles});

    // Next-state and next-output computation for the vote FSM.
    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        consec_d = consec_q;
        mism_d   = mism_q;
        to_d     = to_q;
        mc_d     = mc_q;
        valid_d  = valid_q;
        hist_d   = hist_q;
        lp_d     = 1'b0;
        cp_d     = 1'b0;
        tp_d     = 1'b0;

        if (!enable) begin
            state_d  = ST_SEARCH;
            valid_d  = 1'b0;
            consec_d = '0;
            mism_d   = '0;
            to_d     = '0;
        end else begin
            if (any_edge) begin
                valid_d = 1'b1;
                hist_d  = hist_q | edge_vec;
            end
            case (state_q)
                ST_SEARCH: begin
                    if (any_edge) begin
                        cand_d   = win_enc;
                        consec_d = LOCK_CW'(1);
                        mc_d     = CNT_W'(1);
                        mism_d   = '0;
                        to_d     = '0;
                        cp_d     = (win_enc != cand_q);
                        if (LOCK_THRESHOLD == 1) begin
                            state_d = ST_LOCKED;
                            lp_d    = 1'b1;
                        end else begin
                            state_d = ST_TRACK;
                        end
                    end
                end
                ST_TRACK: begin
                    if (match) begin
                        consec_d = (&consec_q) ? consec_q : consec_q + 1'b1;
                        mc_d     = (&mc_q) ? mc_q : mc_q + 1'b1;
                        if (int'(consec_q) + 1 == LOCK_THRESHOLD) begin
                            state_d = ST_LOCKED;
                            lp_d    = 1'b1;
                            mism_d  = '0;
                            to_d    = '0;
                        end
                    end else if (any_edge) begin
                        cand_d   = win_enc;
                        consec_d = LOCK_CW'(1);
                        mc_d     = CNT_W'(1);
                        cp_d     = 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (match) begin
                        mism_d = '0;
                        mc_d   = (&mc_q) ? mc_q : mc_q + 1'b1;
                        to_d   = '0;
                    end else begin
                        // A mismatching edge does not restart the loss-of-sync timer.
                        to_d = (&to_q) ? to_q : to_q + 1'b1;
                        if (any_edge && (int'(mism_q) + 1 == UNLOCK_THRESHOLD)) begin
                            state_d  = ST_TRACK;
                            cand_d   = win_enc;
                            consec_d = LOCK_CW'(1);
                            mc_d     = CNT_W'(1);
                            mism_d   = '0;
                            to_d     = '0;
                            cp_d     = 1'b1;
                        end else if (timeout_hit) begin
                            state_d  = ST_TRACK;
                            consec_d = '0;
                            mism_d   = '0;
                            to_d     = '0;
                            tp_d     = 1'b1;
                        end else if (any_edge) begin
                            mism_d = (&mism_q) ? mism_q : mism_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_SEARCH;
                end
            endcase
        end
    end

    // State and output registers; reset and clear override everything else.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state_q  <= ST_SEARCH;
            cand_q   <= ENC_W'(ENC_MFM);
            consec_q <= '0;
            mism_q   <= '0;
            to_q     <= '0;
            mc_q     <= '0;
            valid_q  <= 1'b0;
            hist_q   <= '0;
            lp_q     <= 1'b0;
            cp_q     <= 1'b0;
            tp_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            consec_q <= consec_d;
            mism_q   <= mism_d;
            to_q     <= to_d;
            mc_q     <= mc_d;
            valid_q  <= valid_d;
            hist_q   <= hist_d;
            lp_q     <= lp_d;
            cp_q     <= cp_d;
            tp_q     <= tp_d;
        end
    end

    assign detected_encoding = cand_q;
    assign encoding_valid    = valid_q;
    assign encoding_locked   = (state_q == ST_LOCKED);
    assign lock_pulse        = lp_q;
    assign change_pulse      = cp_q;
    assign timeout_pulse     = tp_q;
    assign match_count       = mc_q;
    assign sync_history      = hist_q;

endmodule

// File: tb/tb_encoding_vote_detector.sv
// Directed bench for encoding_vote_detector with a stamped expected-output queue.
module tb_encoding_vote_detector;
    import encoding_pkg::*;

    localparam int W = 24;

    logic        clk = 1'b0;
    logic        reset, enable, clear;
    logic [7:0]  sync_in, src_mask;
    logic [23:0] src_enc;
    logic [19:0] timeout_cycles;
    logic [2:0]  detected_encoding;
    logic        encoding_valid, encoding_locked;
    logic        lock_pulse, change_pulse, timeout_pulse;
    logic [7:0]  match_count, sync_history;

    encoding_vote_detector dut (
        .clk               (clk),
        .reset             (reset),
        .enable            (enable),
        .clear             (clear),
        .sync_in           (sync_in),
        .src_enc           (src_enc),
        .src_mask          (src_mask),
        .timeout_cycles    (timeout_cycles),
        .detected_encoding (detected_encoding),
        .encoding_valid    (encoding_valid),
        .encoding_locked   (encoding_locked),
        .lock_pulse        (lock_pulse),
        .change_pulse      (change_pulse),
        .timeout_pulse     (timeout_pulse),
        .match_count       (match_count),
        .sync_history      (sync_history)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int           stamp_q[$];
    string        name_q[$];
    int           n_vec = 0;
    int           n_err = 0;
    logic         done = 1'b0;

    function automatic string fmt(input logic [W-1:0] v);
        return $sformatf("enc=%0d valid=%b locked=%b lp=%b cp=%b tp=%b mc=%0d hist=%b",
                         v[23:21], v[20], v[19], v[18], v[17], v[16], v[15:8], v[7:0]);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic expect_at(input int stamp, input string nm, input logic [2:0] enc,
                             input logic valid, input logic locked, input logic lp,
                             input logic cp, input logic tp, input logic [7:0] mc,
                             input logic [7:0] hist);
        exp_q.push_back({enc, valid, locked, lp, cp, tp, mc, hist});
        stamp_q.push_back(stamp);
        name_q.push_back(nm);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fire(input logic [7:0] v);
        sync_in = v;
        idle(1);
        sync_in = '0;
    endtask

    // ---------------- monitor / checker ----------------
    logic [W-1:0] act, e;
    int           st;
    string        nm;

    always @(negedge clk) begin
        act = {detected_encoding, encoding_valid, encoding_locked, lock_pulse,
               change_pulse, timeout_pulse, match_count, sync_history};
        while (exp_q.size() > 0 && stamp_q[0] <= cyc) begin
            e  = exp_q.pop_front();
            st = stamp_q.pop_front();
            nm = name_q.pop_front();
            n_vec++;
            if (st < cyc) begin
                n_err++;
                $display("FAIL %s: check for cycle %0d skipped (now %0d), need %s", nm, st, cyc, fmt(e));
            end else if (act !== e) begin
                n_err++;
                $display("FAIL %s @cycle %0d: got %s, need %s", nm, cyc, fmt(act), fmt(e));
            end
        end
        if (done) begin
            while (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                st = stamp_q.pop_front();
                nm = name_q.pop_front();
                n_vec++;
                n_err++;
                $display("FAIL %s: never checked (cycle %0d), need %s", nm, st, fmt(e));
            end
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
            $finish;
        end
    end

    // ---------------- stimulus ----------------
    int s;

    initial begin
        reset          = 1'b1;
        clear          = 1'b0;
        enable         = 1'b1;
        sync_in        = 8'b0000_0010;   // source 1 high through reset release
        src_mask       = '0;
        timeout_cycles = '0;
        src_enc = {ENC_FM, ENC_MFM, ENC_TANDY, ENC_GCR_AP5,
                   ENC_MFM, ENC_GCR_C64, ENC_FM, ENC_GCR_AP6};

        // Reset state
        @(posedge clk);
        #1;
        expect_at(cyc + 1, "reset", 3'd0, 0, 0, 0, 0, 0, 8'd0, 8'h00);
        idle(1);
        reset = 1'b0;

        // Level already high at reset is not an edge
        expect_at(cyc + 3, "level_at_reset", 3'd0, 0, 0, 0, 0, 0, 8'd0, 8'h00);
        idle(3);
        sync_in = '0;
        idle(1);

        // Masked source toggling has no effect
        src_mask = 8'h10;
        repeat (3) begin
            fire(8'h10);
            idle(1);
        end
        expect_at(cyc + 1, "masked", 3'd0, 0, 0, 0, 0, 0, 8'd0, 8'h00);
        idle(1);
        src_mask = '0;
        idle(1);

        // Three AP6 edges on source 0, ten cycles apart
        expect_at(cyc + 1, "ap6_first", ENC_GCR_AP6, 1, 0, 0, 1, 0, 8'd1, 8'h01);
        fire(8'h01);
        expect_at(cyc + 1, "ap6_first_after", ENC_GCR_AP6, 1, 0, 0, 0, 0, 8'd1, 8'h01);
        idle(9);
        expect_at(cyc + 1, "ap6_second", ENC_GCR_AP6, 1, 0, 0, 0, 0, 8'd2, 8'h01);
        fire(8'h01);
        idle(9);
        expect_at(cyc + 1, "ap6_lock", ENC_GCR_AP6, 1, 1, 1, 0, 0, 8'd3, 8'h01);
        fire(8'h01);
        expect_at(cyc + 1, "ap6_lock_after", ENC_GCR_AP6, 1, 1, 0, 0, 0, 8'd3, 8'h01);
        idle(3);

        // Nine mismatching MFM edges keep the lock, the tenth switches
        repeat (9) begin
            fire(8'h08);
            idle(1);
        end
        expect_at(cyc, "mismatch_9", ENC_GCR_AP6, 1, 1, 0, 0, 0, 8'd3, 8'h09);
        expect_at(cyc + 1, "mismatch_10", ENC_MFM, 1, 0, 0, 1, 0, 8'd1, 8'h09);
        fire(8'h08);
        idle(2);

        // Reset while tracking
        reset = 1'b1;
        expect_at(cyc + 1, "reset_mid_track", 3'd0, 0, 0, 0, 0, 0, 8'd0, 8'h00);
        idle(1);
        reset = 1'b0;
        idle(1);

        // Simultaneous edges on sources 2 and 5: source 2 wins
        expect_at(cyc + 1, "simul_2_5", ENC_GCR_C64, 1, 0, 0, 1, 0, 8'd1, 8'h24);
        fire(8'h24);
        idle(1);

        // Lock on C64 and let the 100-cycle timeout expire
        timeout_cycles = 20'd100;
        expect_at(cyc + 1, "c64_match2", ENC_GCR_C64, 1, 0, 0, 0, 0, 8'd2, 8'h24);
        fire(8'h04);
        idle(1);
        s = cyc + 1;
        expect_at(s, "c64_lock", ENC_GCR_C64, 1, 1, 1, 0, 0, 8'd3, 8'h24);
        expect_at(s + 99, "pre_timeout", ENC_GCR_C64, 1, 1, 0, 0, 0, 8'd3, 8'h24);
        expect_at(s + 100, "timeout", ENC_GCR_C64, 1, 0, 0, 0, 1, 8'd3, 8'h24);
        expect_at(s + 101, "post_timeout", ENC_GCR_C64, 1, 0, 0, 0, 0, 8'd3, 8'h24);
        fire(8'h04);
        idle(102);

        // Relock from TRACK with consec restarted at zero
        fire(8'h04);
        idle(1);
        fire(8'h04);
        idle(1);
        expect_at(cyc + 1, "relock", ENC_GCR_C64, 1, 1, 1, 0, 0, 8'd6, 8'h24);
        fire(8'h04);
        idle(2);

        // Drop enable while locked; edges are then ignored
        enable = 1'b0;
        expect_at(cyc + 1, "disable", ENC_GCR_C64, 0, 0, 0, 0, 0, 8'd6, 8'h24);
        idle(1);
        expect_at(cyc + 1, "disabled_edge", ENC_GCR_C64, 0, 0, 0, 0, 0, 8'd6, 8'h24);
        fire(8'h01);
        idle(2);

        // Soft clear returns everything to reset values
        clear = 1'b1;
        expect_at(cyc + 1, "clear", 3'd0, 0, 0, 0, 0, 0, 8'd0, 8'h00);
        idle(1);
        clear = 1'b0;
        idle(2);

        done = 1'b1;
        idle(5);
        $display("FAIL monitor: summary not reached");
        $fatal(1);
    end

endmodule
